// File: rtl/piano_pkg.sv
// Shared definitions for the piano key renderer: colour codes, note tables
// and the black-key size ratios.
package piano_pkg;

  typedef enum logic [2:0] {
    C_EMPTY      = 3'd0,
    C_WHITE_UP   = 3'd1,
    C_WHITE_DOWN = 3'd2,
    C_BLACK_UP   = 3'd3,
    C_BLACK_DOWN = 3'd4,
    C_WHITE_FADE = 3'd5,
    C_BLACK_FADE = 3'd6
  } color_t;

  // Black key is 6/8 of the white width and 10/16 of the white height.
  localparam int unsigned BLACK_W_NUM   = 6;
  localparam int unsigned BLACK_W_SHIFT = 3;
  localparam int unsigned BLACK_H_NUM   = 10;
  localparam int unsigned BLACK_H_SHIFT = 4;

  // Note 0..11 within an octave (Do..Si): is it a black key?
  function automatic logic noteIsBlack(input int unsigned n);
    case (n)
      1, 3, 6, 8, 10: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // White slot (0..6) of a white note; for a black note, the slot of the
  // white key it follows.
  function automatic int unsigned noteWhiteSlot(input int unsigned n);
    case (n)
      0, 1:    return 0;
      2, 3:    return 1;
      4:       return 2;
      5, 6:    return 3;
      7, 8:    return 4;
      9, 10:   return 5;
      default: return 6;
    endcase
  endfunction

endpackage

// File: rtl/piano_fade_bank.sv
// Per-key release-fade counters with a single combinational read port.
module piano_fade_bank #(
  parameter int unsigned KEYS      = 24,
  parameter int unsigned FADE_BITS = 4,
  parameter int unsigned IDX_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [KEYS-1:0]      pressed,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [FADE_BITS-1:0] rd_level
);

  logic [FADE_BITS-1:0] level [KEYS];

  // Pressed keys load full fade (wins over decay); released keys decay once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < KEYS; k++) level[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < KEYS; k++) begin
        if (pressed[k])
          level[k] <= '1;
        else if (frame_start && (level[k] != '0))
          level[k] <= level[k] - 1'b1;
      end
    end
  end

  assign rd_level = (32'(rd_idx) < KEYS) ? level[rd_idx] : '0;

endmodule

// File: rtl/piano_key_renderer.sv
// Three-stage pixel classifier for an on-screen piano keyboard.
// S1: hit flags per key, S2: priority encode + pressed/fade sample, S3: colour.
module piano_key_renderer
  import piano_pkg::*;
#(
  parameter int unsigned POS_BITS  = 10,
  parameter int unsigned DIM_BITS  = 10,
  parameter int unsigned OCTAVES   = 2,
  parameter int unsigned FADE_BITS = 4,
  parameter int unsigned IDX_BITS  = $clog2(12 * OCTAVES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [DIM_BITS-1:0]    key_width,
  input  logic [DIM_BITS-1:0]    key_height,
  input  logic [DIM_BITS-1:0]    key_space,
  input  logic [POS_BITS-1:0]    pos_x,
  input  logic [POS_BITS-1:0]    pos_y,
  input  logic                   eval_valid,
  input  logic [POS_BITS-1:0]    eval_x,
  input  logic [POS_BITS-1:0]    eval_y,
  input  logic [12*OCTAVES-1:0]  pressed,
  output logic                   out_valid,
  output logic [2:0]             color,
  output logic [IDX_BITS-1:0]    key_index,
  output logic [FADE_BITS-1:0]   fade_level
);

  localparam int unsigned KEYS = 12 * OCTAVES;
  localparam int unsigned XW   = POS_BITS + 4;

  logic [DIM_BITS-1:0] gKw, gKh, gKs;
  logic [POS_BITS-1:0] gPx, gPy;

  // Geometry only changes at frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      gKw <= '0; gKh <= '0; gKs <= '0; gPx <= '0; gPy <= '0;
    end else if (frame_start) begin
      gKw <= key_width; gKh <= key_height; gKs <= key_space;
      gPx <= pos_x;     gPy <= pos_y;
    end
  end

  logic [XW-1:0] ex, ey, px, py, kw, kh, step, bw, bh, blackOff;
  logic          inWhiteY, inBlackY;
  logic [KEYS-1:0] hitNow;

  assign ex       = XW'(eval_x);
  assign ey       = XW'(eval_y);
  assign px       = XW'(gPx);
  assign py       = XW'(gPy);
  assign kw       = XW'(gKw);
  assign kh       = XW'(gKh);
  assign step     = XW'(gKw) + XW'(gKs);
  assign bw       = XW'(gKw >> BLACK_W_SHIFT) * XW'(BLACK_W_NUM);
  assign bh       = XW'(gKh >> BLACK_H_SHIFT) * XW'(BLACK_H_NUM);
  assign blackOff = XW'(gKs >> 1) + (bw >> 1);
  assign inWhiteY = (ey >= py) && (ey < py + kh);
  assign inBlackY = (ey >= py) && (ey < py + bh);

  for (genvar k = 0; k < KEYS; k++) begin : gKey
    localparam int unsigned NOTE = k % 12;
    localparam int unsigned SLOT = 7 * (k / 12) + noteWhiteSlot(NOTE);
    logic [XW-1:0] left, right;
    if (noteIsBlack(NOTE)) begin : gBlack
      // Black key straddles the boundary after its white key, centred on the gap.
      assign left  = px + XW'(SLOT + 1) * step - blackOff;
      assign right = left + bw;
      assign hitNow[k] = inBlackY && (ex >= left) && (ex < right);
    end else begin : gWhite
      assign left  = px + XW'(SLOT) * step;
      assign right = left + kw;
      assign hitNow[k] = inWhiteY && (ex >= left) && (ex < right);
    end
  end

  logic            s1Valid;
  logic [KEYS-1:0] s1Hit;

  // S1: register per-key hit flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Hit   <= '0;
    end else begin
      s1Valid <= eval_valid;
      s1Hit   <= hitNow;
    end
  end

  logic                encHit, encBlack;
  logic [IDX_BITS-1:0] encIdx;

  // S2 encode: any black hit wins over a white hit; lowest index within a class.
  always_comb begin
    encHit   = 1'b0;
    encBlack = 1'b0;
    encIdx   = '0;
    for (int unsigned k = 0; k < KEYS; k++) begin
      if (!encHit && s1Hit[k] && noteIsBlack(k % 12)) begin
        encHit = 1'b1; encBlack = 1'b1; encIdx = IDX_BITS'(k);
      end
    end
    for (int unsigned k = 0; k < KEYS; k++) begin
      if (!encHit && s1Hit[k]) begin
        encHit = 1'b1; encIdx = IDX_BITS'(k);
      end
    end
  end

  logic [FADE_BITS-1:0] rdLevel;

  piano_fade_bank #(
    .KEYS      (KEYS),
    .FADE_BITS (FADE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) uFade (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pressed     (pressed),
    .rd_idx      (encIdx),
    .rd_level    (rdLevel)
  );

  logic                 s2Valid, s2Hit, s2Black, s2Pressed;
  logic [IDX_BITS-1:0]  s2Idx;
  logic [FADE_BITS-1:0] s2Fade;

  // S2: register encoded key along with its pressed bit and current fade.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0; s2Hit <= 1'b0; s2Black <= 1'b0; s2Pressed <= 1'b0;
      s2Idx   <= '0;   s2Fade <= '0;
    end else begin
      s2Valid   <= s1Valid;
      s2Hit     <= encHit;
      s2Black   <= encBlack;
      s2Pressed <= pressed[encIdx];
      s2Idx     <= encIdx;
      s2Fade    <= rdLevel;
    end
  end

  color_t nextColor;

  // S3 colour: pressed beats fading beats idle.
  always_comb begin
    nextColor = C_EMPTY;
    if (s2Hit) begin
      if (s2Pressed)
        nextColor = s2Black ? C_BLACK_DOWN : C_WHITE_DOWN;
      else if (s2Fade != '0)
        nextColor = s2Black ? C_BLACK_FADE : C_WHITE_FADE;
      else
        nextColor = s2Black ? C_BLACK_UP : C_WHITE_UP;
    end
  end

  // S3: output registers, held while no valid pixel arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; color <= '0; key_index <= '0; fade_level <= '0;
    end else begin
      out_valid <= s2Valid;
      if (s2Valid) begin
        color      <= nextColor;
        key_index  <= s2Hit ? s2Idx : '0;
        fade_level <= s2Hit ? s2Fade : '0;
      end
    end
  end

endmodule

// File: tb/tb_piano_key_renderer.sv
// Bench for piano_key_renderer: directed table, corner sequences and a
// randomized run checked against a geometric reference model.
module tb_piano_key_renderer;

  localparam int POS_BITS  = 10;
  localparam int DIM_BITS  = 10;
  localparam int OCTAVES   = 2;
  localparam int FADE_BITS = 4;
  localparam int KEYS      = 12 * OCTAVES;
  localparam int IDX_BITS  = $clog2(KEYS);
  localparam int FADE_MAX  = (1 << FADE_BITS) - 1;

  logic                 clk = 1'b0;
  logic                 rst, frame_start, eval_valid;
  logic [DIM_BITS-1:0]  key_width, key_height, key_space;
  logic [POS_BITS-1:0]  pos_x, pos_y, eval_x, eval_y;
  logic [KEYS-1:0]      pressed;
  logic                 out_valid;
  logic [2:0]           color;
  logic [IDX_BITS-1:0]  key_index;
  logic [FADE_BITS-1:0] fade_level;

  piano_key_renderer #(
    .POS_BITS (POS_BITS),
    .DIM_BITS (DIM_BITS),
    .OCTAVES  (OCTAVES),
    .FADE_BITS(FADE_BITS)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .key_width(key_width), .key_height(key_height), .key_space(key_space),
    .pos_x(pos_x), .pos_y(pos_y),
    .eval_valid(eval_valid), .eval_x(eval_x), .eval_y(eval_y),
    .pressed(pressed),
    .out_valid(out_valid), .color(color), .key_index(key_index), .fade_level(fade_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // ---------------- reference model ----------------
  // White slot within the octave for each note (black notes: slot they follow).
  int wslot [12] = '{0, 0, 1, 1, 2, 3, 3, 4, 4, 5, 5, 6};
  int isBlk [12] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0};

  typedef struct { bit v; bit hit; bit blk; int idx; bit prs; int fade; } px_t;

  int  mKw, mKh, mKs, mPx, mPy;
  int  mFade [KEYS];
  px_t m1, m2;
  bit  eValid;
  int  eColor, eIdx, eFade;

  function automatic px_t classify(int x, int y);
    px_t r;
    int step, bw, bh, w, left, wid, ht;
    r = '{0, 0, 0, 0, 0, 0};
    step = mKw + mKs;
    bw = (mKw / 8) * 6;
    bh = (mKh / 16) * 10;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < KEYS; k++) begin
        if (!r.hit && (isBlk[k % 12] == (pass == 0 ? 1 : 0))) begin
          w = 7 * (k / 12) + wslot[k % 12];
          if (pass == 0) begin
            left = mPx + (w + 1) * step - mKs / 2 - bw / 2; wid = bw; ht = bh;
          end else begin
            left = mPx + w * step; wid = mKw; ht = mKh;
          end
          if (x >= left && x < left + wid && y >= mPy && y < mPy + ht) begin
            r.hit = 1; r.blk = (pass == 0); r.idx = k;
          end
        end
      end
    end
    return r;
  endfunction

  // At each falling edge: compare DUT outputs with model, then advance the
  // model by the inputs the coming rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        vectors++;
        if (out_valid !== eValid || int'(color) != eColor ||
            int'(key_index) != eIdx || int'(fade_level) != eFade) begin
          miscompares++;
          $display("FAIL model t=%0t valid/color/idx/fade got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                   $time, out_valid, color, key_index, fade_level, eValid, eColor, eIdx, eFade);
        end
      end
      if (rst) begin
        m1 = '{0, 0, 0, 0, 0, 0}; m2 = '{0, 0, 0, 0, 0, 0};
        eValid = 0; eColor = 0; eIdx = 0; eFade = 0;
        for (int k = 0; k < KEYS; k++) mFade[k] = 0;
        mKw = 0; mKh = 0; mKs = 0; mPx = 0; mPy = 0;
      end else begin
        eValid = m2.v;
        if (m2.v) begin
          if (!m2.hit) begin
            eColor = 0; eIdx = 0; eFade = 0;
          end else begin
            eIdx = m2.idx; eFade = m2.fade;
            if (m2.prs)          eColor = m2.blk ? 4 : 2;
            else if (m2.fade > 0) eColor = m2.blk ? 6 : 5;
            else                 eColor = m2.blk ? 3 : 1;
          end
        end
        m2 = m1;
        m2.prs  = pressed[m1.idx];
        m2.fade = mFade[m1.idx];
        m1 = classify(int'(eval_x), int'(eval_y));
        m1.v = eval_valid;
        for (int k = 0; k < KEYS; k++) begin
          if (pressed[k]) mFade[k] = FADE_MAX;
          else if (frame_start && mFade[k] > 0) mFade[k] = mFade[k] - 1;
        end
        if (frame_start) begin
          mKw = int'(key_width); mKh = int'(key_height); mKs = int'(key_space);
          mPx = int'(pos_x);     mPy = int'(pos_y);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct { int x; int y; int p; int color; int idx; int fade; } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [KEYS-1:0] bitOf(int k);
    logic [KEYS-1:0] r;
    r = '0;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  task automatic setGeom(int kw, int kh, int ks, int px, int py);
    key_width = DIM_BITS'(kw); key_height = DIM_BITS'(kh); key_space = DIM_BITS'(ks);
    pos_x = POS_BITS'(px); pos_y = POS_BITS'(py);
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
  endtask

  // Hold one pixel long enough to flush the pipeline, then check constants.
  task automatic applyVec(input vec_t v, input int id);
    eval_valid = 1'b1;
    eval_x = POS_BITS'(v.x); eval_y = POS_BITS'(v.y);
    pressed = bitOf(v.p);
    repeat (4) tick();
    #2;
    vectors++;
    if (out_valid !== 1'b1 || int'(color) != v.color ||
        int'(key_index) != v.idx || int'(fade_level) != v.fade) begin
      miscompares++;
      $display("FAIL vec%0d (%0d,%0d) valid/color/idx/fade got %0d/%0d/%0d/%0d expected 1/%0d/%0d/%0d",
               id, v.x, v.y, out_valid, color, key_index, fade_level, v.color, v.idx, v.fade);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; frame_start = 1'b0; eval_valid = 1'b0;
    eval_x = '0; eval_y = '0; pressed = '0;
    setGeom(20, 80, 2, 100, 50);
    repeat (3) tick();
    checkEn = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || color != 3'd0 || key_index != '0 || fade_level != '0) begin
      miscompares++;
      $display("FAIL reset valid/color/idx/fade got %0d/%0d/%0d/%0d expected 0/0/0/0",
               out_valid, color, key_index, fade_level);
    end
    rst = 1'b0;
    tick();
    pulseFrame();

    // x, y, pressed key (-1 none), colour, index, fade
    tbl.push_back('{105, 120, -1, 1,  0,  0});
    tbl.push_back('{118,  60, -1, 3,  1,  0});
    tbl.push_back('{118,  60,  1, 4,  1, 15});
    tbl.push_back('{120, 120, -1, 0,  0,  0});
    tbl.push_back('{100, 130, -1, 0,  0,  0});
    tbl.push_back('{260, 120, 12, 2, 12, 15});
    tbl.push_back('{269,  60, -1, 3, 13,  0});
    tbl.push_back('{268,  60, -1, 5, 12, 15});
    tbl.push_back('{273, 120, -1, 5, 12, 15});
    tbl.push_back('{274, 120, -1, 0,  0,  0});
    tbl.push_back('{276, 120, -1, 1, 14,  0});
    tbl.push_back('{118,  60, -1, 6,  1, 15});
    tbl.push_back('{115,  99, -1, 6,  1, 15});
    tbl.push_back('{115, 100, -1, 1,  0,  0});
    tbl.push_back('{126,  60, -1, 6,  1, 15});
    tbl.push_back('{127,  60, -1, 1,  2,  0});
    tbl.push_back('{ 99,  60, -1, 0,  0,  0});
    tbl.push_back('{100,  50, -1, 1,  0,  0});
    tbl.push_back('{100,  49, -1, 0,  0,  0});
    for (int i = 0; i < tbl.size(); i++) applyVec(tbl[i], i);

    // Release fade over frames.
    eval_valid = 1'b0;
    repeat (3) pulseFrame();
    applyVec('{118, 60, -1, 6, 1, 12}, 100);
    repeat (12) pulseFrame();
    applyVec('{118, 60, -1, 3, 1, 0}, 101);
    applyVec('{260, 120, -1, 1, 12, 0}, 102);

    // Reset in the middle of a stream of valid pixels.
    for (int c = 0; c < 10; c++) begin
      eval_valid = 1'b1; eval_x = 10'd105; eval_y = 10'd120;
      rst = (c == 5);
      tick();
      if (c >= 5 && c <= 7) begin
        #2;
        vectors++;
        if (out_valid !== 1'b0 || (c == 5 && color != 3'd0)) begin
          miscompares++;
          $display("FAIL rst_flush c=%0d valid/color got %0d/%0d expected 0/0", c, out_valid, color);
        end
      end
    end
    rst = 1'b0;

    // Geometry change without frame_start has no effect until the next frame.
    setGeom(20, 80, 2, 100, 50);
    pulseFrame();
    key_width = 10'd30;
    applyVec('{121, 120, -1, 0, 0, 0}, 200);
    pulseFrame();
    applyVec('{121, 120, -1, 1, 0, 0}, 201);

    // Randomized run against the reference model.
    setGeom($urandom_range(8, 40), $urandom_range(16, 200), $urandom_range(0, 5),
            $urandom_range(0, 200), $urandom_range(0, 200));
    pulseFrame();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0)
        setGeom($urandom_range(8, 40), $urandom_range(16, 200), $urandom_range(0, 5),
                $urandom_range(0, 200), $urandom_range(0, 200));
      frame_start = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 599) == 0);
      eval_valid  = ($urandom_range(0, 3) != 0);
      eval_x = POS_BITS'($urandom_range(0, 900));
      eval_y = POS_BITS'($urandom_range(0, 450));
      if ($urandom_range(0, 7) == 0) pressed = KEYS'($urandom & $urandom & $urandom);
      tick();
    end
    rst = 1'b0; frame_start = 1'b0; eval_valid = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
